// File: rtl/dma_axi64_rd_resp.sv
// AXI 64-bit read responder: queues AR commands and returns bursts of
// address-derived pattern data ({~addr, addr}) with optional SLVERR.
module dma_axi64_rd_resp #(
  parameter int          ID_BITS    = 4,
  parameter int          LEN_BITS   = 4,
  parameter int          SIZE_BITS  = 2,
  parameter int          CMD_DEPTH  = 4,
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] ERR_BASE   = 32'hFFFF0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ID_BITS-1:0]   ARID,
  input  logic [31:0]          ARADDR,
  input  logic [LEN_BITS-1:0]  ARLEN,
  input  logic [SIZE_BITS-1:0] ARSIZE,
  input  logic                 ARVALID,
  output logic                 ARREADY,
  output logic [ID_BITS-1:0]   RID,
  output logic [63:0]          RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY,
  output logic                 busy
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int WW = $clog2(RD_LATENCY + 2) + 1;
  localparam logic [PW:0]   FULL_C = CMD_DEPTH[PW:0];
  localparam logic [PW:0]   CNT1_C = {{PW{1'b0}}, 1'b1};
  localparam logic [WW-1:0] LAT_C  = RD_LATENCY[WW-1:0];
  localparam logic [WW-1:0] W1_C   = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] B1_C = {{(LEN_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_e;

  logic [ID_BITS-1:0]   id_mem   [CMD_DEPTH];
  logic [31:0]          addr_mem [CMD_DEPTH];
  logic [LEN_BITS-1:0]  len_mem  [CMD_DEPTH];
  logic [SIZE_BITS-1:0] size_mem [CMD_DEPTH];

  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q, count_d;
  state_e               state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [LEN_BITS-1:0]  beat_q, beat_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [SIZE_BITS-1:0] size_q, size_d;
  logic [31:0]          addr_q, addr_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic                 err_q, err_d;

  logic        full, push, hs, last, pop;
  logic [31:0] bsz, next_addr;

  assign full    = (count_q == FULL_C);
  assign ARREADY = !reset && !full;
  assign push    = ARVALID && ARREADY;
  assign hs      = RVALID && RREADY;
  assign last    = (beat_q == len_q);
  assign pop     = hs && last;

  assign bsz       = 32'd1 << size_q;
  assign next_addr = (addr_q & ~(bsz - 32'd1)) + bsz;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT1_C;
    else if (pop && !push)
      count_d = count_q - CNT1_C;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    len_d   = len_q;
    size_d  = size_q;
    addr_d  = addr_q;
    id_d    = id_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_WAIT;
          wait_d  = LAT_C;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          // head entry stays in the FIFO until its last beat is taken
          state_d = S_BURST;
          id_d    = id_mem[rd_ptr_q];
          addr_d  = addr_mem[rd_ptr_q];
          len_d   = len_mem[rd_ptr_q];
          size_d  = size_mem[rd_ptr_q];
          err_d   = (addr_mem[rd_ptr_q] >= ERR_BASE);
          beat_d  = '0;
        end else begin
          wait_d = wait_q - W1_C;
        end
      end
      S_BURST: begin
        if (hs) begin
          if (last) begin
            state_d = (count_d != '0) ? S_WAIT : S_IDLE;
            wait_d  = LAT_C;
          end else begin
            beat_d = beat_q + B1_C;
            addr_d = next_addr;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      err_q   <= err_d;
      count_q <= count_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= ARID;
      addr_mem[wr_ptr_q] <= ARADDR;
      len_mem[wr_ptr_q]  <= ARLEN;
      size_mem[wr_ptr_q] <= ARSIZE;
    end
  end

  assign RVALID = (state_q == S_BURST);
  assign RID    = RVALID ? id_q : '0;
  assign RDATA  = RVALID ? {~addr_q, addr_q} : 64'd0;
  assign RRESP  = (RVALID && err_q) ? 2'b10 : 2'b00;
  assign RLAST  = RVALID && last;
  assign busy   = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_dma_axi64_rd_resp.sv
// Scoreboard bench for dma_axi64_rd_resp: directed AR commands push
// expected beats; a negedge monitor pops and compares every R handshake.
module tb_dma_axi64_rd_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [1:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic        busy;

  always #5 clk = ~clk;

  dma_axi64_rd_resp dut (
    .clk(clk), .reset(reset),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  int    nbeats   = 0;
  bit    stall    = 1'b0;
  beat_t prev;
  bit    stop_tgl;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_beat(input logic [3:0] id, input logic [31:0] a,
                          input logic [1:0] r, input logic l);
    beat_t b;
    b.id   = id;
    b.data = {~a, a};
    b.resp = r;
    b.last = l;
    sb.push_back(b);
  endtask

  // monitor: compares handshakes and holds stalled beats stable
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = '{RID, RDATA, RRESP, RLAST};
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_rvalid", 64'(RVALID), 64'd1);
        chk("stall_beat", 64'(cur), 64'(prev));
      end
      if (RVALID && RREADY) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", RDATA);
        end else begin
          e = sb.pop_front();
          chk("rid", 64'(RID), 64'(e.id));
          chk("rdata", RDATA, e.data);
          chk("rresp", 64'(RRESP), 64'(e.resp));
          chk("rlast", 64'(RLAST), 64'(e.last));
          nbeats++;
        end
      end
      stall = RVALID && !RREADY;
      prev  = cur;
    end
  end

  task automatic send(input logic [3:0] id, input logic [31:0] a,
                      input logic [3:0] len, input logic [1:0] sz);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    ARID    = id;
    ARADDR  = a;
    ARLEN   = len;
    ARSIZE  = sz;
    ARVALID = 1'b1;
    for (int k = 0; k < 200; k++) begin
      ok = ARREADY;
      @(posedge clk);
      if (ok) break;
      #1;
    end
    #1;
    chk("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic ar_idle();
    ARVALID = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 500; k++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain_done", 64'(k < 500), 64'd1);
  endtask

  initial begin
    int n;
    int base;
    reset   = 1'b1;
    ARVALID = 1'b0;
    ARID    = '0;
    ARADDR  = '0;
    ARLEN   = '0;
    ARSIZE  = '0;
    RREADY  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 64'(ARREADY), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdata", RDATA, 64'd0);
    chk("rst_out", 64'({RID, RRESP, RLAST}), 64'd0);
    chk("rst_arready_after", 64'(ARREADY), 64'd1);

    // 1: basic 4-beat burst and first-beat latency
    exp_beat(4'd5, 32'h100, 2'b00, 1'b0);
    exp_beat(4'd5, 32'h108, 2'b00, 1'b0);
    exp_beat(4'd5, 32'h110, 2'b00, 1'b0);
    exp_beat(4'd5, 32'h118, 2'b00, 1'b1);
    send(4'd5, 32'h100, 4'd3, 2'd3);
    ar_idle();
    for (n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (RVALID) break;
    end
    chk("t1_latency", 64'(n - 1), 64'(LAT + 2));
    drain();

    // 2: FIFO fills, fifth command waits for the first pop
    #1 RREADY = 1'b0;
    exp_beat(4'd1, 32'h1000, 2'b00, 1'b0);
    exp_beat(4'd1, 32'h1008, 2'b00, 1'b1);
    exp_beat(4'd2, 32'h2000, 2'b00, 1'b1);
    exp_beat(4'd3, 32'h3000, 2'b00, 1'b0);
    exp_beat(4'd3, 32'h3008, 2'b00, 1'b0);
    exp_beat(4'd3, 32'h3010, 2'b00, 1'b1);
    exp_beat(4'd4, 32'h4000, 2'b00, 1'b0);
    exp_beat(4'd4, 32'h4008, 2'b00, 1'b1);
    exp_beat(4'd6, 32'h5000, 2'b00, 1'b1);
    send(4'd1, 32'h1000, 4'd1, 2'd3);
    send(4'd2, 32'h2000, 4'd0, 2'd3);
    send(4'd3, 32'h3000, 4'd2, 2'd3);
    send(4'd4, 32'h4000, 4'd1, 2'd3);
    ar_idle();
    chk("t2_full_arready", 64'(ARREADY), 64'd0);
    base = nbeats;
    fork
      send(4'd6, 32'h5000, 4'd0, 2'd3);
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("t2_still_full", 64'(ARREADY), 64'd0);
        RREADY = 1'b1;
      end
    join
    ar_idle();
    chk("t2_fifth_after_pop", 64'(nbeats - base), 64'd2);
    drain();

    // 3: RREADY toggling on an 8-beat burst
    for (int k = 0; k < 8; k++)
      exp_beat(4'd3, 32'h200 + 32'(8 * k), 2'b00, 1'(k == 7));
    base = nbeats;
    stop_tgl = 1'b0;
    fork
      begin
        forever begin
          @(posedge clk);
          #1;
          if (stop_tgl) break;
          RREADY = ~RREADY;
        end
      end
    join_none
    send(4'd3, 32'h200, 4'd7, 2'd3);
    ar_idle();
    drain();
    stop_tgl = 1'b1;
    @(posedge clk);
    #2 RREADY = 1'b1;
    chk("t3_beats", 64'(nbeats - base), 64'd8);

    // 4: SLVERR region and 32-bit address wrap
    exp_beat(4'd6, 32'hFFFF0004, 2'b10, 1'b0);
    exp_beat(4'd6, 32'hFFFF0008, 2'b10, 1'b1);
    send(4'd6, 32'hFFFF0004, 4'd1, 2'd2);
    exp_beat(4'd7, 32'hFFFFFFF8, 2'b10, 1'b0);
    exp_beat(4'd7, 32'h00000000, 2'b10, 1'b1);
    send(4'd7, 32'hFFFFFFF8, 4'd1, 2'd3);
    ar_idle();
    drain();

    // 5: unaligned start realigns after first beat
    exp_beat(4'd1, 32'h103, 2'b00, 1'b0);
    exp_beat(4'd1, 32'h104, 2'b00, 1'b0);
    exp_beat(4'd1, 32'h108, 2'b00, 1'b1);
    send(4'd1, 32'h103, 4'd2, 2'd2);
    ar_idle();
    drain();

    // 6: reset mid-burst with two commands queued
    for (int k = 0; k < 8; k++)
      exp_beat(4'd9, 32'h400 + 32'(8 * k), 2'b00, 1'(k == 7));
    exp_beat(4'd10, 32'h500, 2'b00, 1'b0);
    exp_beat(4'd10, 32'h508, 2'b00, 1'b1);
    exp_beat(4'd11, 32'h600, 2'b00, 1'b1);
    base = nbeats;
    send(4'd9, 32'h400, 4'd7, 2'd3);
    send(4'd10, 32'h500, 4'd1, 2'd3);
    send(4'd11, 32'h600, 4'd0, 2'd3);
    ar_idle();
    for (n = 0; n < 100; n++) begin
      @(posedge clk);
      #2;
      if (nbeats - base >= 2) break;
    end
    chk("t6_reach_beat2", 64'(nbeats - base), 64'd2);
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_rvalid", 64'(RVALID), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    repeat (10) @(posedge clk);
    exp_beat(4'd12, 32'h700, 2'b00, 1'b0);
    exp_beat(4'd12, 32'h708, 2'b00, 1'b1);
    send(4'd12, 32'h700, 4'd1, 2'd3);
    ar_idle();
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
